// File: rtl/mem_if_pkg.sv
// Shared memory-interface types: arbiter state encoding, owner IDs and bus widths
// used by the arbiter and the cache controllers.
package mem_if_pkg;
   localparam int ADDR_W  = 28;
   localparam int BLOCK_W = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-side signals around the arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int BLOCK_SIZE = BLOCK_W
) ();
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_valid;
   logic [BLOCK_SIZE-1:0] i_rd;
   logic                  i_ready;

   logic [ADDR_WIDTH-1:0] d_addr;
   logic [BLOCK_SIZE-1:0] d_wr;
   logic                  d_rw;
   logic                  d_valid;
   logic [BLOCK_SIZE-1:0] d_rd;
   logic                  d_ready;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [BLOCK_SIZE-1:0] mem_wr;
   logic                  mem_rw;
   logic                  mem_valid;
   logic [BLOCK_SIZE-1:0] mem_rd;
   logic                  mem_ready;

   logic [1:0]            grant;
   logic                  timeout_err;

   modport slave (
      input  i_addr, i_valid, d_addr, d_wr, d_rw, d_valid, mem_rd, mem_ready,
      output i_rd, i_ready, d_rd, d_ready, mem_addr, mem_wr, mem_rw, mem_valid,
             grant, timeout_err
   );

   modport master (
      output i_addr, i_valid, d_addr, d_wr, d_rw, d_valid, mem_rd, mem_ready,
      input  i_rd, i_ready, d_rd, d_ready, mem_addr, mem_wr, mem_rw, mem_valid,
             grant, timeout_err
   );
endinterface

// File: rtl/mem_watchdog.sv
// Saturating beat watchdog: counts cycles while enabled, flags when the count
// reaches TIMEOUT. TIMEOUT = 0 disables the flag.
module mem_watchdog #(
   parameter int TIMEOUT   = 1023,
   parameter int CNT_WIDTH = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);
   logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (clr_i) begin
         wd_cnt_d = '0;
      end else if (en_i && (wd_cnt_q != {CNT_WIDTH{1'b1}})) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

   assign timeout_o = (TIMEOUT != 0) && en_i && (wd_cnt_q == CNT_WIDTH'(TIMEOUT));
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache.
// One beat per grant; every beat returns to IDLE so both sides re-arbitrate.
module mem_arbiter
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int BLOCK_SIZE = BLOCK_W,
   parameter int TIMEOUT    = 1023,
   parameter int CNT_WIDTH  = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);
   arb_state_e state_q, state_d;
   owner_e     last_owner_q, last_owner_d;
   logic       wd_clr, wd_en, wd_tmo;

   mem_watchdog #(
      .TIMEOUT   (TIMEOUT),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .timeout_o (wd_tmo)
   );

   always_comb begin
      state_d         = state_q;
      last_owner_d    = last_owner_q;
      wd_clr          = 1'b1;
      wd_en           = 1'b0;
      bus.mem_addr    = {ADDR_WIDTH{1'b0}};
      bus.mem_wr      = {BLOCK_SIZE{1'b0}};
      bus.mem_rw      = 1'b0;
      bus.mem_valid   = 1'b0;
      bus.i_rd        = {BLOCK_SIZE{1'b0}};
      bus.d_rd        = {BLOCK_SIZE{1'b0}};
      bus.i_ready     = 1'b0;
      bus.d_ready     = 1'b0;
      bus.grant       = 2'b00;
      bus.timeout_err = 1'b0;

      case (state_q)
         IDLE: begin
            // On a tie the port that did not own the previous beat wins
            if (bus.i_valid && (!bus.d_valid || last_owner_q == OWN_D)) begin
               state_d = GNT_I;
            end else if (bus.d_valid) begin
               state_d = GNT_D;
            end
         end
         GNT_I: begin
            bus.mem_addr  = bus.i_addr;
            bus.mem_valid = bus.i_valid;
            bus.i_rd      = bus.mem_rd;
            bus.d_rd      = bus.mem_rd;
            bus.grant     = 2'b01;
            wd_clr        = 1'b0;
            wd_en         = 1'b1;
            if (!bus.i_valid || bus.mem_ready || wd_tmo) begin
               state_d      = IDLE;
               last_owner_d = OWN_I;
               wd_clr       = 1'b1;
               bus.i_ready  = bus.i_valid && bus.mem_ready;
               bus.timeout_err = bus.i_valid && !bus.mem_ready && wd_tmo;
            end
         end
         GNT_D: begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wr    = bus.d_wr;
            bus.mem_rw    = bus.d_rw;
            bus.mem_valid = bus.d_valid;
            bus.i_rd      = bus.mem_rd;
            bus.d_rd      = bus.mem_rd;
            bus.grant     = 2'b10;
            wd_clr        = 1'b0;
            wd_en         = 1'b1;
            if (!bus.d_valid || bus.mem_ready || wd_tmo) begin
               state_d      = IDLE;
               last_owner_d = OWN_D;
               wd_clr       = 1'b1;
               bus.d_ready  = bus.d_valid && bus.mem_ready;
               bus.timeout_err = bus.d_valid && !bus.mem_ready && wd_tmo;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_owner_q <= OWN_D;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single beats plus hand-written
// sequences for tie-break, alternation, watchdog, abort and async reset.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         iv;
      logic [27:0]  ia;
      logic         dv;
      logic         drw;
      logic [27:0]  da;
      logic [255:0] dw;
      logic [255:0] rd;
      logic [1:0]   g;
      logic [27:0]  ea;
      logic         erw;
      logic [255:0] ew;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.i_valid   = 1'b0;
      bus.i_addr    = '0;
      bus.d_valid   = 1'b0;
      bus.d_rw      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wr      = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rd    = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Waits (bounded) for the next cycle with mem_valid high, sampled at negedge
   task automatic wait_valid(input string nm);
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         if (bus.mem_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk({nm, "_wait_valid"}, 256'(0), 256'(1));
   endtask

   task automatic pulse_ready(input logic [255:0] rd);
      bus.mem_ready = 1'b1;
      bus.mem_rd    = rd;
      @(negedge clk);
      bus.mem_ready = 1'b0;
   endtask

   initial begin
      logic [255:0] a5;
      logic [1:0]   prev_g;
      int           t;

      a5 = {32{8'hA5}};
      vecs[0] = '{1'b1, 28'h0000300, 1'b1, 1'b1, 28'h0000100, 256'h1234, {8{32'h11112222}},
                  2'b10, 28'h0000100, 1'b1, 256'h1234};
      vecs[1] = '{1'b1, 28'h0000080, 1'b1, 1'b0, 28'h0000104, 256'h77, {8{32'h33334444}},
                  2'b01, 28'h0000080, 1'b0, 256'h0};
      vecs[2] = '{1'b0, 28'h0000000, 1'b1, 1'b0, 28'h0000200, 256'h0, {8{32'h55556666}},
                  2'b10, 28'h0000200, 1'b0, 256'h0};
      vecs[3] = '{1'b0, 28'h0000000, 1'b1, 1'b1, 28'h0000204, 256'hDEAD, {8{32'h77778888}},
                  2'b10, 28'h0000204, 1'b1, 256'hDEAD};
      vecs[4] = '{1'b1, 28'hFFFFFFF, 1'b1, 1'b1, 28'h0000208, 256'hBEEF, {8{32'h9999AAAA}},
                  2'b01, 28'hFFFFFFF, 1'b0, 256'h0};
      vecs[5] = '{1'b1, 28'h0000001, 1'b0, 1'b0, 28'h0000000, 256'h0, {8{32'hBBBBCCCC}},
                  2'b01, 28'h0000001, 1'b0, 256'h0};

      clear_inputs();
      do_reset();

      // Reset/IDLE outputs, and mem_ready while IDLE is ignored
      #1;
      chk("rst_mem_valid", 256'(bus.mem_valid), 256'(0));
      chk("rst_grant", 256'(bus.grant), 256'(0));
      chk("rst_mem_addr", 256'(bus.mem_addr), 256'(0));
      chk("rst_mem_rw", 256'(bus.mem_rw), 256'(0));
      chk("rst_mem_wr", bus.mem_wr, 256'(0));
      chk("rst_timeout", 256'(bus.timeout_err), 256'(0));
      bus.mem_ready = 1'b1;
      #1;
      chk("idle_ready_ign", 256'({bus.i_ready, bus.d_ready}), 256'(0));
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      chk("idle_ready_state", 256'(bus.grant), 256'(0));

      // Single I read: one-cycle arbitration latency, ready passed through
      bus.i_valid = 1'b1;
      bus.i_addr  = 28'h0000040;
      #1;
      chk("t1_cycle1_valid", 256'(bus.mem_valid), 256'(0));
      @(negedge clk);
      #1;
      chk("t1_mem_valid", 256'(bus.mem_valid), 256'(1));
      chk("t1_mem_addr", 256'(bus.mem_addr), 256'(28'h0000040));
      chk("t1_mem_rw", 256'(bus.mem_rw), 256'(0));
      bus.mem_ready = 1'b1;
      bus.mem_rd    = a5;
      #1;
      chk("t1_i_ready", 256'(bus.i_ready), 256'(1));
      chk("t1_i_rd", bus.i_rd, a5);
      chk("t1_d_ready", 256'(bus.d_ready), 256'(0));
      @(negedge clk);
      clear_inputs();
      #1;
      chk("t1_idle_grant", 256'(bus.grant), 256'(0));
      chk("t1_idle_valid", 256'(bus.mem_valid), 256'(0));

      // Table of beats; last owner entering the table is I
      for (int v = 0; v < 6; v++) begin
         bus.i_valid = vecs[v].iv;
         bus.i_addr  = vecs[v].ia;
         bus.d_valid = vecs[v].dv;
         bus.d_rw    = vecs[v].drw;
         bus.d_addr  = vecs[v].da;
         bus.d_wr    = vecs[v].dw;
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_grant", v), 256'(bus.grant), 256'(vecs[v].g));
         chk($sformatf("v%0d_mem_valid", v), 256'(bus.mem_valid), 256'(1));
         chk($sformatf("v%0d_mem_addr", v), 256'(bus.mem_addr), 256'(vecs[v].ea));
         chk($sformatf("v%0d_mem_rw", v), 256'(bus.mem_rw), 256'(vecs[v].erw));
         chk($sformatf("v%0d_mem_wr", v), bus.mem_wr, vecs[v].ew);
         bus.mem_ready = 1'b1;
         bus.mem_rd    = vecs[v].rd;
         #1;
         chk($sformatf("v%0d_ready", v), 256'({bus.d_ready, bus.i_ready}), 256'(vecs[v].g));
         chk($sformatf("v%0d_rd", v), vecs[v].g[0] ? bus.i_rd : bus.d_rd, vecs[v].rd);
         @(negedge clk);
         clear_inputs();
         #1;
         chk($sformatf("v%0d_bubble", v), 256'(bus.grant), 256'(0));
      end

      // Simultaneous requests after reset: I first, D after the bubble
      do_reset();
      bus.i_valid = 1'b1;
      bus.i_addr  = 28'h0000300;
      bus.d_valid = 1'b1;
      bus.d_rw    = 1'b1;
      bus.d_addr  = 28'h0000400;
      bus.d_wr    = 256'h1234;
      @(negedge clk);
      #1;
      chk("t2_first_grant", 256'(bus.grant), 256'(2'b01));
      chk("t2_i_mem_wr", bus.mem_wr, 256'(0));
      chk("t2_i_mem_rw", 256'(bus.mem_rw), 256'(0));
      pulse_ready(a5);
      #1;
      chk("t2_bubble", 256'(bus.grant), 256'(0));
      @(negedge clk);
      #1;
      chk("t2_second_grant", 256'(bus.grant), 256'(2'b10));
      chk("t2_d_mem_wr", bus.mem_wr, 256'h1234);
      chk("t2_d_mem_rw", 256'(bus.mem_rw), 256'(1));
      chk("t2_d_mem_addr", 256'(bus.mem_addr), 256'(28'h0000400));
      pulse_ready(a5);
      clear_inputs();

      // Both held for six beats, memory answers on the third valid cycle
      do_reset();
      bus.i_valid = 1'b1;
      bus.i_addr  = 28'h0000500;
      bus.d_valid = 1'b1;
      bus.d_addr  = 28'h0000600;
      prev_g = 2'b00;
      for (int b = 0; b < 6; b++) begin
         wait_valid($sformatf("t3_b%0d", b));
         chk($sformatf("t3_b%0d_grant", b), 256'(bus.grant), 256'((b % 2 == 0) ? 2'b01 : 2'b10));
         if (b > 0) chk($sformatf("t3_b%0d_alternate", b), 256'(bus.grant == prev_g), 256'(0));
         prev_g = bus.grant;
         repeat (2) @(negedge clk);
         pulse_ready({8{32'(b)}});
      end
      clear_inputs();

      // Watchdog: D never gets ready; pending I is served after the abort
      do_reset();
      bus.d_valid = 1'b1;
      bus.d_rw    = 1'b1;
      bus.d_addr  = 28'h0000700;
      @(negedge clk);
      #1;
      chk("t4_grant_d", 256'(bus.grant), 256'(2'b10));
      chk("t4_no_early_tmo", 256'(bus.timeout_err), 256'(0));
      bus.i_valid = 1'b1;
      t = 0;
      for (int c = 2; c <= 1200; c++) begin
         @(negedge clk);
         #1;
         if (bus.timeout_err) begin
            t = c;
            break;
         end
      end
      chk("t4_tmo_cycle", 256'(t), 256'(1024));
      @(negedge clk);
      #1;
      chk("t4_tmo_once", 256'(bus.timeout_err), 256'(0));
      chk("t4_idle_after", 256'(bus.grant), 256'(0));
      @(negedge clk);
      #1;
      chk("t4_i_next", 256'(bus.grant), 256'(2'b01));
      clear_inputs();

      // D aborts in the same cycle memory answers: no ready forwarded
      do_reset();
      bus.d_valid = 1'b1;
      bus.d_addr  = 28'h0000800;
      @(negedge clk);
      #1;
      chk("t5_grant_d", 256'(bus.grant), 256'(2'b10));
      bus.d_valid   = 1'b0;
      bus.mem_ready = 1'b1;
      bus.mem_rd    = a5;
      #1;
      chk("t5_d_ready", 256'(bus.d_ready), 256'(0));
      chk("t5_no_tmo", 256'(bus.timeout_err), 256'(0));
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      chk("t5_idle", 256'(bus.grant), 256'(0));
      chk("t5_valid_low", 256'(bus.mem_valid), 256'(0));

      // Async reset mid-beat; last owner returns to D so I wins the tie
      do_reset();
      bus.i_valid = 1'b1;
      bus.i_addr  = 28'h0000900;
      @(negedge clk);
      pulse_ready(a5);
      bus.i_valid = 1'b0;
      bus.d_valid = 1'b1;
      bus.d_addr  = 28'h0000A00;
      wait_valid("t6");
      chk("t6_grant_d", 256'(bus.grant), 256'(2'b10));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 256'(bus.mem_valid), 256'(0));
      chk("t6_async_grant", 256'(bus.grant), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_valid = 1'b1;
      @(negedge clk);
      #1;
      chk("t6_tie_to_i", 256'(bus.grant), 256'(2'b01));
      clear_inputs();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
